conv3x3_stream: RTL and testbench

// - Pipelined 3x3 convolution engine. Generalises the fixed-kernel convolver:
//   - parametrised pixel and coefficient widths;
//   - runtime kernel selection, including a loadable custom kernel;
//   - output shift normalisation and selectable abs/clamp modes;
//   - valid/ready streaming with full backpressure.
// - Sits between the line-buffer/window generator (upstream) and the pixel output stage.
//

---
 rtl/conv3x3_stream_if.sv | 31 +++
 rtl/conv3x3_stream.sv | 164 ++++++++++++++++
 tb/tb_conv3x3_stream.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_stream_if.sv
// Valid/ready streaming bundle for the 3x3 convolution engine: window beats in,
// result pixels out, plus the custom-coefficient write port.
interface conv3x3_stream_if #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [9*PIX_W-1:0]     in_window;
  logic [1:0]             kernel_sel;
  logic [3:0]             shift;
  logic                   abs_mode;
  logic                   cfg_we;
  logic [3:0]             cfg_addr;
  logic [COEF_W-1:0]      cfg_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [PIX_W-1:0]       out_pixel;

  modport slave (
    input  in_valid, in_window, kernel_sel, shift, abs_mode,
    input  cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, out_valid, out_pixel
  );

  modport master (
    output in_valid, in_window, kernel_sel, shift, abs_mode,
    output cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, out_valid, out_pixel
  );
endinterface

// File: rtl/conv3x3_stream.sv
// Three-stage pipelined 3x3 convolver: products, sum, magnitude/shift/saturate,
// with fixed and loadable kernels and a single global advance for backpressure.

module conv3x3_coef_rf #(
  parameter int COEF_W = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [3:0]            addr,
  input  logic [COEF_W-1:0]     data,
  output logic [9*COEF_W-1:0]   coef_flat
);
  // Resets to the identity kernel; addresses 9..15 decode to nothing.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < 9; k++) begin
        coef_flat[k*COEF_W +: COEF_W] <= (k == 4) ? COEF_W'(1) : '0;
      end
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (we && (addr == 4'(k))) begin
          coef_flat[k*COEF_W +: COEF_W] <= data;
        end
      end
    end
  end
endmodule

module conv3x3_stream #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = PIX_W + COEF_W + 4
) (
  input  logic             clk,
  input  logic             resetn,
  conv3x3_stream_if.slave  bus
);
  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int SOBX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int SOBY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  logic                     en;
  logic                     accept;
  logic [9*COEF_W-1:0]      cust;
  logic signed [COEF_W-1:0] kc [9];
  logic signed [PROD_W-1:0] px_e [9];
  logic signed [PROD_W-1:0] cf_e [9];
  logic signed [PROD_W-1:0] prod_d [9];

  logic                     v1;
  logic signed [PROD_W-1:0] prod_q [9];
  logic [3:0]               sh1;
  logic                     ab1;

  logic                     v2;
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  sum_q;
  logic [3:0]               sh2;
  logic                     ab2;

  logic                     v3;
  logic [ACC_W-1:0]         mag;
  logic [ACC_W-1:0]         shifted;
  logic [PIX_W-1:0]         pix_d;
  logic [PIX_W-1:0]         pix_q;

  conv3x3_coef_rf #(.COEF_W(COEF_W)) u_coef_rf (
    .clk       (clk),
    .resetn    (resetn),
    .we        (bus.cfg_we),
    .addr      (bus.cfg_addr),
    .data      (bus.cfg_data),
    .coef_flat (cust)
  );

  // Every stage moves together; a full output register with no taker freezes all.
  assign en           = !v3 || bus.out_ready;
  assign accept       = bus.in_valid && en;
  assign bus.in_ready = en;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      kc[k] = '0;
      unique case (bus.kernel_sel)
        2'b00: kc[k] = cust[k*COEF_W +: COEF_W];
        2'b01: kc[k] = COEF_W'(SOBX[k]);
        2'b10: kc[k] = COEF_W'(SOBY[k]);
        2'b11: kc[k] = COEF_W'(1);
        default: kc[k] = '0;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      px_e[k]   = PROD_W'({1'b0, bus.in_window[k*PIX_W +: PIX_W]});
      cf_e[k]   = PROD_W'(kc[k]);
      prod_d[k] = px_e[k] * cf_e[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v1  <= 1'b0;
      sh1 <= '0;
      ab1 <= 1'b0;
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
    end else if (en) begin
      v1 <= accept;
      if (accept) begin
        sh1 <= bus.shift;
        ab1 <= bus.abs_mode;
        for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
      sum_d = sum_d + ACC_W'(prod_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v2    <= 1'b0;
      sum_q <= '0;
      sh2   <= '0;
      ab2   <= 1'b0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        sum_q <= sum_d;
        sh2   <= sh1;
        ab2   <= ab1;
      end
    end
  end

  always_comb begin
    mag = $unsigned(sum_q);
    if (sum_q < 0) begin
      mag = ab2 ? $unsigned(-sum_q) : '0;
    end
    shifted = mag >> sh2;
    pix_d   = (|shifted[ACC_W-1:PIX_W]) ? '1 : shifted[PIX_W-1:0];
  end

  // The output register only loads real results, so it holds during stalls and bubbles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      v3    <= 1'b0;
      pix_q <= '0;
    end else if (en) begin
      v3 <= v2;
      if (v2) pix_q <= pix_d;
    end
  end

  assign bus.out_valid = v3;
  assign bus.out_pixel = pix_q;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: kernels, modes, custom writes, backpressure, reset.
module tb_conv3x3_stream;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  conv3x3_stream_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus ();

  conv3x3_stream #(.PIX_W(PIX_W), .COEF_W(COEF_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int win [9];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_win();
    for (int k = 0; k < 9; k++) bus.in_window[k*PIX_W +: PIX_W] = PIX_W'(win[k]);
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(addr);
    bus.cfg_data = COEF_W'(data);
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // One beat into an idle pipe; optional coefficient write in the same cycle.
  task automatic run_one(input string tag, input int sel, input int sh, input int ab,
                         input int exp, input bit cfg, input int ca, input int cd);
    int lat;
    int pix;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.kernel_sel = 2'(sel);
    bus.shift      = 4'(sh);
    bus.abs_mode   = ab[0];
    drive_win();
    bus.cfg_we     = cfg;
    bus.cfg_addr   = 4'(ca);
    bus.cfg_data   = COEF_W'(cd);
    @(posedge clk);
    lat = 0;
    pix = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
      end
      if (bus.out_valid && lat == 0) begin
        lat = n;
        pix = int'(bus.out_pixel);
      end
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_pix"}, pix, exp);
  endtask

  task automatic backpressure();
    int got [$];
    int idx;
    int prev_pix;
    bit prev_stall;
    bit saw_block;
    int cyc;
    idx = 0;
    prev_stall = 1'b0;
    prev_pix = 0;
    saw_block = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 4 && cyc <= 8);
      if (idx < 6) begin
        bus.in_valid   = 1'b1;
        bus.kernel_sel = 2'b01;
        bus.shift      = 4'd2;
        bus.abs_mode   = 1'b1;
        win = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        win[2] = 11 * (idx + 1);
        win[5] = 11 * (idx + 1);
        win[8] = 11 * (idx + 1);
        drive_win();
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (prev_stall) chk("bp_hold", int'(bus.out_pixel), prev_pix);
      if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
      if (bus.out_valid && bus.out_ready) got.push_back(int'(bus.out_pixel));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pix   = int'(bus.out_pixel);
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    chk("bp_in_ready_fell", int'(saw_block), 1);
    chk("bp_count", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) chk($sformatf("bp_order%0d", i), got[i], 11 * (i + 1));
    end
  endtask

  task automatic reset_midstream();
    int leaks;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.kernel_sel = 2'b11;
      bus.shift      = 4'd0;
      bus.abs_mode   = 1'b1;
      win = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
      win[4] = 10 * (b + 1);
      drive_win();
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("rst_full_before", int'(bus.out_valid), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_pixel", int'(bus.out_pixel), 0);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    leaks = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.out_valid) leaks++;
    end
    chk("rst_no_leak", leaks, 0);
  endtask

  initial begin
    resetn         = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_window  = '0;
    bus.kernel_sel = 2'b00;
    bus.shift      = 4'd0;
    bus.abs_mode   = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = 4'd0;
    bus.cfg_data   = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_pixel", int'(bus.out_pixel), 0);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    resetn = 1'b1;

    win = '{10, 10, 50, 10, 10, 50, 10, 10, 50};
    run_one("sobx_pos", 1, 0, 1, 160, 1'b0, 0, 0);
    win = '{50, 10, 10, 50, 10, 10, 50, 10, 10};
    run_one("sobx_abs", 1, 0, 1, 160, 1'b0, 0, 0);
    run_one("sobx_clamp", 1, 0, 0, 0, 1'b0, 0, 0);
    win = '{0, 0, 200, 0, 0, 200, 0, 0, 200};
    run_one("sobx_sat", 1, 0, 1, 255, 1'b0, 0, 0);
    win = '{10, 10, 10, 0, 0, 0, 30, 30, 30};
    run_one("soby_sh1", 2, 1, 1, 40, 1'b0, 0, 0);
    win = '{30, 30, 30, 0, 0, 0, 10, 10, 10};
    run_one("soby_clamp", 2, 1, 0, 0, 1'b0, 0, 0);
    win = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    run_one("blur_sh3", 3, 3, 1, 112, 1'b0, 0, 0);
    run_one("blur_sat", 3, 0, 1, 255, 1'b0, 0, 0);

    win = '{0, 0, 0, 0, 77, 0, 0, 0, 0};
    run_one("cust_ident", 0, 0, 1, 77, 1'b0, 0, 0);
    cfg_write(4, 2);
    cfg_write(0, 255);
    win = '{20, 0, 0, 0, 100, 0, 0, 0, 0};
    run_one("cust_load", 0, 0, 1, 180, 1'b0, 0, 0);
    cfg_write(12, 5);
    run_one("cust_badaddr", 0, 0, 1, 180, 1'b0, 0, 0);
    win = '{20, 0, 0, 0, 50, 0, 0, 0, 0};
    run_one("cust_samecyc", 0, 0, 1, 80, 1'b1, 4, 3);
    run_one("cust_after", 0, 0, 1, 130, 1'b0, 0, 0);

    backpressure();
    reset_midstream();

    win = '{20, 0, 0, 0, 77, 0, 0, 0, 0};
    run_one("rst_coef_ident", 0, 0, 1, 77, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
